// File: rtl/seg_pkg.sv
// Shared definitions for the segment scan controller:
// hex-to-segment table, control-page filler byte, scan states.
package seg_pkg;

  localparam logic [7:0] CTL_BLANK = 8'h00;

  // segments a..g,dp on bits 7..0; entry k encodes digit k
  localparam logic [15:0][7:0] SEG_HEX = {
    8'h8E, 8'h9E, 8'h7A, 8'h1A,
    8'h3E, 8'hEE, 8'hF6, 8'hFE,
    8'hE0, 8'hBE, 8'hB6, 8'h66,
    8'hF2, 8'hDA, 8'h60, 8'hFC
  };

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } scan_state_t;

endpackage

// File: rtl/seg7_hex_dec.sv
// Combinational hex digit to seven-segment byte decoder.
// Table lookup only; no state.
module seg7_hex_dec
  import seg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [7:0] seg
);

  assign seg = SEG_HEX[hex];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scanner: pages through a register file
// and a control byte with blanking gaps between digit groups.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NREG  = 16,
  parameter int DIV   = 33333,
  parameter int BLANK = 1,
  parameter int HOLD  = 2,
  localparam int NPAGE = NREG / 2,
  localparam int PW    = $clog2(NPAGE + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [16*NREG-1:0] regs,
  input  logic [7:0]         ctl,
  input  logic               manual,
  input  logic [PW-1:0]      page_sel,
  input  logic               freeze,
  output logic [63:0]        disp,
  output logic [NPAGE:0]     sl_out,
  output logic [PW-1:0]      page,
  output logic               frame_done
);

  localparam int DW   = $clog2(DIV);
  localparam int TMAX = (BLANK > HOLD) ? BLANK : HOLD;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [DW-1:0] DIV_LAST   = DW'(DIV - 1);
  localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK - 1);
  localparam logic [TW-1:0] HOLD_LAST  = TW'(HOLD - 1);
  localparam logic [PW-1:0] CTL_PAGE   = PW'(NPAGE);

  logic [DW-1:0] cnt;
  logic [TW-1:0] tcnt;
  scan_state_t   state;
  logic [PW-1:0] nxt_page;
  logic          tick;

  logic [15:0]    word_a;
  logic [15:0]    word_b;
  logic [63:0]    seg_bytes;
  logic [63:0]    disp_load;
  logic [NPAGE:0] sl_load;
  logic [PW-1:0]  sel_clamp;
  logic [PW-1:0]  auto_next;
  logic           is_ctl;

  assign tick   = (cnt == DIV_LAST) && !freeze;
  assign is_ctl = (nxt_page == CTL_PAGE);

  always_comb begin
    word_a = '0;
    word_b = '0;
    for (int p = 0; p < NPAGE; p++) begin
      if (nxt_page == PW'(p)) begin
        word_a = regs[32*p +: 16];
        word_b = regs[32*p+16 +: 16];
      end
    end
  end

  for (genvar gi = 0; gi < 8; gi++) begin : g_dig
    logic [3:0] nib;
    if (gi < 4) begin : g_a
      assign nib = word_a[4*(3-gi) +: 4];
    end else begin : g_b
      assign nib = word_b[4*(7-gi) +: 4];
    end
    seg7_hex_dec u_dec (
      .hex (nib),
      .seg (seg_bytes[8*gi +: 8])
    );
  end

  assign disp_load = is_ctl ? {{7{CTL_BLANK}}, ctl} : seg_bytes;

  // data page p lights the group at the mirrored position
  always_comb begin
    sl_load = '0;
    if (is_ctl) begin
      sl_load[NPAGE] = 1'b1;
    end else begin
      for (int p = 0; p < NPAGE; p++) begin
        if (nxt_page == PW'(p)) sl_load[NPAGE-1-p] = 1'b1;
      end
    end
  end

  assign sel_clamp = (page_sel > CTL_PAGE) ? CTL_PAGE : page_sel;
  assign auto_next = (page == CTL_PAGE) ? '0 : page + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      tcnt       <= '0;
      state      <= ST_BLANK;
      nxt_page   <= '0;
      page       <= '0;
      disp       <= '0;
      sl_out     <= '0;
      frame_done <= 1'b0;
    end else if (!freeze) begin
      frame_done <= 1'b0;
      cnt        <= (cnt == DIV_LAST) ? '0 : cnt + 1'b1;
      if (tick) begin
        unique case (state)
          ST_BLANK: begin
            if (tcnt == BLANK_LAST) begin
              tcnt   <= '0;
              state  <= ST_SHOW;
              page   <= nxt_page;
              disp   <= disp_load;
              sl_out <= sl_load;
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end
          ST_SHOW: begin
            if (tcnt == HOLD_LAST) begin
              tcnt       <= '0;
              state      <= ST_BLANK;
              sl_out     <= '0;
              nxt_page   <= manual ? sel_clamp : auto_next;
              frame_done <= !manual && (page == CTL_PAGE);
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: vector table, directed corner sequences,
// and random stimulus against a tick-schedule reference model.
module tb_seg_scan_ctrl;

  localparam int NREG  = 4;
  localparam int DIV   = 4;
  localparam int BLANK = 1;
  localparam int HOLD  = 2;
  localparam int NPAGE = NREG / 2;

  localparam logic [63:0] P0 = 64'hFEE0BEB666F2DA60;
  localparam logic [63:0] P1 = 64'hFCFCFCFCFCFCFCFC;
  localparam logic [63:0] P2 = 64'h00000000000000A5;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] regs;
  logic [7:0]  ctl;
  logic        manual;
  logic [1:0]  page_sel;
  logic        freeze;
  logic [63:0] disp;
  logic [2:0]  sl_out;
  logic [1:0]  page;
  logic        frame_done;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] hex_tab [16] = '{
    8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
    8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h1A, 8'h7A, 8'h9E, 8'h8E
  };

  seg_scan_ctrl #(
    .NREG(NREG), .DIV(DIV), .BLANK(BLANK), .HOLD(HOLD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .regs       (regs),
    .ctl        (ctl),
    .manual     (manual),
    .page_sel   (page_sel),
    .freeze     (freeze),
    .disp       (disp),
    .sl_out     (sl_out),
    .page       (page),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  // reference: divider position, ticks into the current page slot
  int          m_div, m_slot, m_page, m_next;
  logic [63:0] m_disp;
  logic [2:0]  m_sl;
  logic        m_fd;

  function automatic logic [63:0] exp_disp(int p, logic [63:0] r,
                                           logic [7:0] c);
    logic [63:0] d;
    d = '0;
    if (p == NPAGE) begin
      d[7:0] = c;
    end else begin
      for (int i = 0; i < 8; i++) begin
        int w;
        int sh;
        w  = 2 * p + i / 4;
        sh = 12 - 4 * (i % 4);
        d[8*i +: 8] = hex_tab[int'((r >> (16 * w + sh)) & 64'hF)];
      end
    end
    return d;
  endfunction

  function automatic logic [2:0] exp_sel(int p);
    if (p == NPAGE) return 3'(1 << NPAGE);
    return 3'(1 << (NPAGE - 1 - p));
  endfunction

  task automatic model_edge();
    if (rst) begin
      m_div = 0; m_slot = 0; m_page = 0; m_next = 0;
      m_disp = '0; m_sl = '0; m_fd = 1'b0;
    end else if (!freeze) begin
      m_fd = 1'b0;
      if (m_div == DIV - 1) begin
        m_div = 0;
        m_slot++;
        if (m_slot == BLANK) begin
          m_page = m_next;
          m_disp = exp_disp(m_next, regs, ctl);
          m_sl   = exp_sel(m_next);
        end else if (m_slot == BLANK + HOLD) begin
          m_slot = 0;
          m_sl   = '0;
          if (manual) begin
            m_next = (int'(page_sel) > NPAGE) ? NPAGE : int'(page_sel);
          end else begin
            m_next = (m_page + 1) % (NPAGE + 1);
            m_fd   = (m_page == NPAGE);
          end
        end
      end else begin
        m_div++;
      end
    end
  endtask

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    n_cmp++;
    if (disp !== m_disp || sl_out !== m_sl ||
        page !== 2'(m_page) || frame_done !== m_fd) begin
      n_err++;
      $display("FAIL model @%0t: disp=%h sl=%b pg=%0d fd=%b want %h %b %0d %b",
               $time, disp, sl_out, page, frame_done,
               m_disp, m_sl, m_page, m_fd);
    end
    chk("onehot", 64'($countones(sl_out) <= 1), 64'd1);
  endtask

  typedef struct {
    int          clks;
    logic [2:0]  sl;
    logic [1:0]  pg;
    logic        fd;
    logic [63:0] d;
  } vec_t;

  vec_t vt [8];

  initial begin
    int n_fd, n_bad, n_on, n_off, guard;

    vt[0] = '{4, 3'b010, 2'd0, 1'b0, P0};
    vt[1] = '{8, 3'b000, 2'd0, 1'b0, P0};
    vt[2] = '{4, 3'b001, 2'd1, 1'b0, P1};
    vt[3] = '{8, 3'b000, 2'd1, 1'b0, P1};
    vt[4] = '{4, 3'b100, 2'd2, 1'b0, P2};
    vt[5] = '{8, 3'b000, 2'd2, 1'b1, P2};
    vt[6] = '{1, 3'b000, 2'd2, 1'b0, P2};
    vt[7] = '{3, 3'b010, 2'd0, 1'b0, P0};

    rst = 1'b1; regs = 64'h0000_0000_5678_1234; ctl = 8'hA5;
    manual = 1'b0; page_sel = '0; freeze = 1'b0;
    step();
    chk("rst_disp", disp, 64'd0);
    chk("rst_sl", 64'(sl_out), 64'd0);
    chk("rst_page", 64'(page), 64'd0);
    chk("rst_fd", 64'(frame_done), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      repeat (vt[i].clks) step();
      chk($sformatf("vec%0d_sl", i), 64'(sl_out), 64'(vt[i].sl));
      chk($sformatf("vec%0d_pg", i), 64'(page), 64'(vt[i].pg));
      chk($sformatf("vec%0d_fd", i), 64'(frame_done), 64'(vt[i].fd));
      chk($sformatf("vec%0d_disp", i), disp, vt[i].d);
    end

    // snapshot: register edit while page 0 is lit
    regs[15:0] = 16'hFFFF;
    step();
    chk("snap_hold", disp, P0);
    repeat (35) step();
    chk("snap_reload", disp, 64'hFEE0BEB68E8E8E8E);
    chk("snap_sl", 64'(sl_out), 64'b010);

    // freeze mid-SHOW, with a mode change buried inside
    repeat (2) step();
    freeze = 1'b1;
    repeat (25) step();
    manual = 1'b1; page_sel = 2'd1;
    repeat (24) step();
    manual = 1'b0;
    step();
    chk("frz_sl", 64'(sl_out), 64'b010);
    chk("frz_disp", disp, 64'hFEE0BEB68E8E8E8E);
    chk("frz_pg", 64'(page), 64'd0);
    freeze = 1'b0;
    repeat (5) step();
    chk("frz_rel_hold", 64'(sl_out), 64'b010);
    step();
    chk("frz_rel_end", 64'(sl_out), 64'b000);

    // manual with out-of-range request
    manual = 1'b1; page_sel = 2'd3;
    n_fd = 0; n_bad = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (frame_done) n_fd++;
      if (i >= 40 && sl_out != 3'b000 && sl_out != 3'b100) n_bad++;
    end
    chk("man3_fd", 64'(n_fd), 64'd0);
    chk("man3_sel", 64'(n_bad), 64'd0);
    chk("man3_pg", 64'(page), 64'd2);

    page_sel = 2'd1;
    repeat (40) step();
    n_bad = 0; n_on = 0; n_off = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (sl_out == 3'b001) n_on++;
      else if (sl_out == 3'b000) n_off++;
      else n_bad++;
    end
    chk("man1_bad", 64'(n_bad), 64'd0);
    chk("man1_on", 64'(n_on > 0), 64'd1);
    chk("man1_off", 64'(n_off > 0), 64'd1);

    // reset while page 1 is lit
    manual = 1'b0;
    guard = 0;
    while (!(m_page == 1 && m_sl != 3'b000) && guard < 200) begin
      step();
      guard++;
    end
    chk("rst_wait", 64'(guard < 200), 64'd1);
    step();
    rst = 1'b1;
    step();
    chk("mrst_disp", disp, 64'd0);
    chk("mrst_sl", 64'(sl_out), 64'd0);
    chk("mrst_pg", 64'(page), 64'd0);
    rst = 1'b0;
    repeat (3) step();
    chk("mrst_pre", 64'(sl_out), 64'd0);
    step();
    chk("mrst_sl1", 64'(sl_out), 64'b010);
    chk("mrst_disp1", disp, 64'hFEE0BEB68E8E8E8E);

    // random traffic
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 7) == 0) regs = {$urandom, $urandom};
      if ($urandom_range(0, 15) == 0) ctl = 8'($urandom);
      if ($urandom_range(0, 39) == 0) manual = ~manual;
      if ($urandom_range(0, 19) == 0) page_sel = 2'($urandom);
      if ($urandom_range(0, 24) == 0) freeze = ~freeze;
      rst = ($urandom_range(0, 299) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
